// File: rtl/cpu_input_pio_edge.sv
// Avalon-MM input PIO: 2-flop synchroniser, per-channel debounce, edge capture (W1C), masked irq.
// Debounce counters are built only when CPU_INPUT_PIO_DEBOUNCE_EN is defined.
module cpu_input_pio_edge #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned EDGE_TYPE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] s1_q, sync_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [31:0]      rdata_q, rdata_d;

  logic             wr_en;
  logic [WIDTH-1:0] clr_bits;
  logic [WIDTH-1:0] rise, fall, set_bits;

  // Only the low WIDTH bits of writedata are decoded.
  logic unused_wdata;
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= '0;
      sync_q <= '0;
    end else begin
      s1_q   <= in_port;
      sync_q <= s1_q;
    end
  end

`ifdef CPU_INPUT_PIO_DEBOUNCE_EN
  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;

  // s1 != sync means sync moves on the next edge, so the stability window restarts.
  always_comb begin
    cnt_d = cnt_q;
    db_d  = db_q;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if ((sync_q[i] == db_q[i]) || (s1_q[i] != sync_q[i])) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CntW'(DEBOUNCE_CYCLES - 1)) begin
        db_d[i]  = sync_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  localparam int unsigned unused_debounce = DEBOUNCE_CYCLES;

  always_comb begin
    db_d = sync_q;
  end
`endif

  assign wr_en    = chipselect & ~write_n;
  assign clr_bits = (wr_en && (address == 2'd3)) ? writedata[WIDTH-1:0] : '0;
  assign rise     = db_d & ~db_q;
  assign fall     = ~db_d & db_q;

  always_comb begin
    if (EDGE_TYPE == 0) begin
      set_bits = rise;
    end else if (EDGE_TYPE == 1) begin
      set_bits = fall;
    end else begin
      set_bits = rise | fall;
    end
  end

  // Set has priority over a same-cycle W1C.
  always_comb begin
    edge_d = (edge_q & ~clr_bits) | set_bits;
    mask_d = mask_q;
    if (wr_en && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rdata_d = '0;
    case (address)
      2'd0:    rdata_d[WIDTH-1:0] = db_q;
      2'd1:    rdata_d[WIDTH-1:0] = sync_q;
      2'd2:    rdata_d[WIDTH-1:0] = mask_q;
      default: rdata_d[WIDTH-1:0] = edge_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q    <= '0;
      mask_q  <= '0;
      edge_q  <= '0;
      rdata_q <= '0;
    end else begin
      db_q    <= db_d;
      mask_q  <= mask_d;
      edge_q  <= edge_d;
      rdata_q <= rdata_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = |(edge_q & mask_q);

endmodule

// File: tb/tb_cpu_input_pio_edge.sv
// Bench for cpu_input_pio_edge: three instances (EDGE_TYPE 0/1/2) on a shared bus, checked
// every cycle against a sample-window reference model, plus directed scenario checks.
module tb_cpu_input_pio_edge;
  localparam int unsigned W = 4;
  localparam int unsigned D = 4;
`ifdef CPU_INPUT_PIO_DEBOUNCE_EN
  localparam int unsigned Lat = 1 + D;
`else
  localparam int unsigned Lat = 2;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [1:0]    address;
  logic          chipselect;
  logic          write_n;
  logic [31:0]   writedata;
  logic [W-1:0]  in_port;
  logic [31:0]   rd0, rd1, rd2;
  logic          irq0, irq1, irq2;

  always #5 clk = ~clk;

  cpu_input_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0)
  );
  cpu_input_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1)
  );
  cpu_input_pio_edge #(.WIDTH(W), .DEBOUNCE_CYCLES(D), .EDGE_TYPE(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2)
  );

  // Reference model: m_hist[0] is the most recent in_port sample, m_hist[1] the one before.
  logic [W-1:0] m_hist [D+1];
  logic [W-1:0] m_db, m_mask;
  logic [W-1:0] m_edge [3];
  logic [31:0]  m_rd [3];
  int n_cmp = 0;
  int n_err = 0;

  task automatic model_reset();
    for (int j = 0; j <= int'(D); j++) m_hist[j] = '0;
    m_db   = '0;
    m_mask = '0;
    for (int k = 0; k < 3; k++) begin
      m_edge[k] = '0;
      m_rd[k]   = '0;
    end
  endtask

  task automatic model_edge();
    logic [W-1:0] nxt, rise, fall, clr, v;
    logic         wr, stable;
    for (int k = 0; k < 3; k++) begin
      case (address)
        2'd0:    v = m_db;
        2'd1:    v = m_hist[1];
        2'd2:    v = m_mask;
        default: v = m_edge[k];
      endcase
      m_rd[k] = {28'b0, v};
    end
    nxt = m_db;
`ifdef CPU_INPUT_PIO_DEBOUNCE_EN
    // Accept a level once the last D+1 raw samples all agree on it.
    for (int b = 0; b < int'(W); b++) begin
      stable = 1'b1;
      for (int j = 0; j <= int'(D); j++) if (m_hist[j][b] != m_hist[0][b]) stable = 1'b0;
      if (stable) nxt[b] = m_hist[0][b];
    end
`else
    nxt = m_hist[1];
`endif
    rise = nxt & ~m_db;
    fall = ~nxt & m_db;
    wr   = chipselect && !write_n;
    clr  = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
    m_edge[0] = (m_edge[0] & ~clr) | rise;
    m_edge[1] = (m_edge[1] & ~clr) | fall;
    m_edge[2] = (m_edge[2] & ~clr) | rise | fall;
    if (wr && address == 2'd2) m_mask = writedata[W-1:0];
    m_db = nxt;
    for (int j = int'(D); j >= 1; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = in_port;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("rd0", rd0, m_rd[0]);
    check("rd1", rd1, m_rd[1]);
    check("rd2", rd2, m_rd[2]);
    check("irq0", {31'b0, irq0}, {31'b0, |(m_edge[0] & m_mask)});
    check("irq1", {31'b0, irq1}, {31'b0, |(m_edge[1] & m_mask)});
    check("irq2", {31'b0, irq2}, {31'b0, |(m_edge[2] & m_mask)});
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    model_reset();
    #1 check_all();
    hold(n);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;
    model_reset();
    @(negedge clk);
    do_reset(3);

    // Reset values on all four registers.
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      tick();
      check("reset_rd", rd0, 32'h0);
    end

    // Stable input then a short pulse on bit 1.
    address = 2'd0;
    in_port = 4'b0001;
    hold(10);
    check("data_after_hold", rd0, 32'h1);
    in_port = 4'b0011;
    hold(3);
    in_port = 4'b0001;
    hold(10);
    address = 2'd3;
    hold(2);

    // Mask then W1C on bit 0.
    bus_write(2'd2, 32'h1);
    address = 2'd0;
    tick();
    check("irq_after_mask", {31'b0, irq0}, 32'h1);
    bus_write(2'd3, 32'h1);
    tick();
    check("irq_after_w1c", {31'b0, irq0}, 32'h0);

    // W1C on bit 2 lands on the same edge the debounced rise sets it.
    in_port = 4'b0101;
    hold(Lat);
    bus_write(2'd3, 32'h4);
    address = 2'd3;
    tick();
    check("set_beats_clear", {31'b0, rd0[2]}, 32'h1);
    bus_write(2'd3, 32'hF);

    // Bit 3 rise, clear, fall: type 1 sets on the fall only, type 2 on both.
    address = 2'd3;
    in_port = 4'b1101;
    hold(12);
    check("fall_type_on_rise", {31'b0, rd1[3]}, 32'h0);
    check("any_type_on_rise", {31'b0, rd2[3]}, 32'h1);
    bus_write(2'd3, 32'h8);
    in_port = 4'b0101;
    hold(12);
    check("fall_type_on_fall", {31'b0, rd1[3]}, 32'h1);
    check("any_type_on_fall", {31'b0, rd2[3]}, 32'h1);

    // Reset two cycles into a debounce window, input held high afterwards.
    bus_write(2'd3, 32'hF);
    in_port = 4'b0000;
    address = 2'd0;
    hold(12);
    in_port = 4'b0001;
    hold(2);
    do_reset(2);
    address = 2'd0;
    hold(10);
    check("data_after_reset", rd0, 32'h1);

    // Randomised traffic.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 3) == 0) in_port = in_port ^ W'(1 << $urandom_range(0, W - 1));
      address    = 2'($urandom_range(0, 3));
      chipselect = 1'($urandom_range(0, 1));
      write_n    = ($urandom_range(0, 3) != 0);
      writedata  = $urandom;
      tick();
    end
    chipselect = 1'b0;
    write_n    = 1'b1;
    hold(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
